// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin sharing of one 4-bit ALU between two requesters.
// Each operation is accepted in IDLE, evaluated in EXEC and held in RESP until
// the owning port takes the tagged result.

module alu_rr_sched_alu (
    input  logic [2:0] func,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] c,
    output logic       carry,
    output logic       overflow,
    output logic       zero
);

    logic [4:0] sum;

    // ALU function decode; only the add codes produce flags
    always_comb begin
        sum      = 5'(a) + 5'(b);
        c        = 4'h0;
        carry    = 1'b0;
        overflow = 1'b0;
        zero     = 1'b0;
        case (func)
            3'b000, 3'b001: begin
                c        = sum[3:0];
                carry    = sum[4];
                overflow = (a[3] == b[3]) && (sum[3] != a[3]);
                zero     = (sum[3:0] == 4'h0);
            end
            3'b010:  c = ~a;
            3'b011:  c = a & b;
            3'b100:  c = a | b;
            3'b101:  c = a ^ b;
            3'b110:  c = (a < b) ? 4'h1 : 4'h0;
            default: c = (a == b) ? 4'h1 : 4'h0;
        endcase
    end

endmodule

module alu_rr_sched (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic       i_req1_valid,
    output logic       o_req0_ready,
    output logic       o_req1_ready,
    input  logic [2:0] i_req0_func,
    input  logic [2:0] i_req1_func,
    input  logic [3:0] i_req0_a,
    input  logic [3:0] i_req0_b,
    input  logic [3:0] i_req1_a,
    input  logic [3:0] i_req1_b,
    output logic       o_rsp0_valid,
    output logic       o_rsp1_valid,
    input  logic       i_rsp0_ready,
    input  logic       i_rsp1_ready,
    output logic [3:0] o_rsp_c,
    output logic       o_rsp_carry,
    output logic       o_rsp_overflow,
    output logic       o_rsp_zero,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       ptr;
    logic       owner;
    logic [2:0] func_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    logic       grant_valid;
    logic       grant_id;
    logic [3:0] alu_c;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic       owner_ready;

    // Grant selection: pointer breaks ties, a lone valid always wins
    always_comb begin
        grant_valid = i_req0_valid | i_req1_valid;
        grant_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = ptr;
        end else if (i_req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Request ready is forced low while reset is held
    assign o_req0_ready = i_rst_n && (state == IDLE) && grant_valid && !grant_id;
    assign o_req1_ready = i_rst_n && (state == IDLE) && grant_valid &&  grant_id;
    assign owner_ready  = owner ? i_rsp1_ready : i_rsp0_ready;

    alu_rr_sched_alu u_alu (
        .func     (func_q),
        .a        (a_q),
        .b        (b_q),
        .c        (alu_c),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    // Scheduler FSM with registered response and busy outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            owner          <= 1'b0;
            func_q         <= 3'h0;
            a_q            <= 4'h0;
            b_q            <= 4'h0;
            o_rsp_c        <= 4'h0;
            o_rsp_carry    <= 1'b0;
            o_rsp_overflow <= 1'b0;
            o_rsp_zero     <= 1'b0;
            o_rsp0_valid   <= 1'b0;
            o_rsp1_valid   <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_id;
                        ptr    <= ~grant_id;
                        func_q <= grant_id ? i_req1_func : i_req0_func;
                        a_q    <= grant_id ? i_req1_a    : i_req0_a;
                        b_q    <= grant_id ? i_req1_b    : i_req0_b;
                        o_busy <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    o_rsp_c        <= alu_c;
                    o_rsp_carry    <= alu_carry;
                    o_rsp_overflow <= alu_overflow;
                    o_rsp_zero     <= alu_zero;
                    o_rsp0_valid   <= !owner;
                    o_rsp1_valid   <= owner;
                    state          <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        o_rsp0_valid <= 1'b0;
                        o_rsp1_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: directed and randomized operations checked
// against an arithmetic ALU model and a round-robin pointer model.

module tb_alu_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_func, req1_func;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [3:0] rsp_c;
    logic       rsp_carry, rsp_overflow, rsp_zero;
    logic       busy;

    int nchecks = 0;
    int nerrors = 0;
    int m_ptr   = 0;

    alu_rr_sched dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req0_valid   (req0_valid),
        .i_req1_valid   (req1_valid),
        .o_req0_ready   (req0_ready),
        .o_req1_ready   (req1_ready),
        .i_req0_func    (req0_func),
        .i_req1_func    (req1_func),
        .i_req0_a       (req0_a),
        .i_req0_b       (req0_b),
        .i_req1_a       (req1_a),
        .i_req1_b       (req1_b),
        .o_rsp0_valid   (rsp0_valid),
        .o_rsp1_valid   (rsp1_valid),
        .i_rsp0_ready   (rsp0_ready),
        .i_rsp1_ready   (rsp1_ready),
        .o_rsp_c        (rsp_c),
        .o_rsp_carry    (rsp_carry),
        .o_rsp_overflow (rsp_overflow),
        .o_rsp_zero     (rsp_zero),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {carry, overflow, zero, c}
    function automatic logic [6:0] alu_ref(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        int          s;
        int          c;
        logic        cy, ov, z;
        int          sa, sb, sc;
        cy = 1'b0; ov = 1'b0; z = 1'b0;
        case (f)
            3'd0, 3'd1: begin
                s  = int'(a) + int'(b);
                c  = s % 16;
                cy = (s >= 16);
                sa = (a >= 8) ? int'(a) - 16 : int'(a);
                sb = (b >= 8) ? int'(b) - 16 : int'(b);
                sc = sa + sb;
                ov = (sc > 7) || (sc < -8);
                z  = (c == 0);
            end
            3'd2:    c = 15 - int'(a);
            3'd3:    c = int'(a & b);
            3'd4:    c = int'(a | b);
            3'd5:    c = int'(a ^ b);
            3'd6:    c = (a < b) ? 1 : 0;
            default: c = (a == b) ? 1 : 0;
        endcase
        return {cy, ov, z, 4'(c)};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp0v"}, rsp0_valid, 0);
        check({tag, "_rsp1v"}, rsp1_valid, 0);
    endtask

    task automatic check_rsp(input string tag, input int g, input logic [6:0] e);
        check({tag, "_rsp0v"}, rsp0_valid, (g == 0));
        check({tag, "_rsp1v"}, rsp1_valid, (g == 1));
        check({tag, "_c"}, rsp_c, e[3:0]);
        check({tag, "_carry"}, rsp_carry, e[6]);
        check({tag, "_ovf"}, rsp_overflow, e[5]);
        check({tag, "_zero"}, rsp_zero, e[4]);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_req0r"}, req0_ready, 0);
        check({tag, "_req1r"}, req1_ready, 0);
    endtask

    // One full operation; called at #1 after a rising edge while DUT is idle
    task automatic issue(input bit v0, input bit v1,
                         input logic [2:0] f0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [2:0] f1, input logic [3:0] a1, input logic [3:0] b1,
                         input int stall, output int g);
        logic [6:0] e;
        req0_valid = v0; req0_func = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_func = f1; req1_a = a1; req1_b = b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        g = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        e = (g == 1) ? alu_ref(f1, a1, b1) : alu_ref(f0, a0, b0);
        check("idle_req0r", req0_ready, (g == 0));
        check("idle_req1r", req1_ready, (g == 1));
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        m_ptr = (g == 0) ? 1 : 0;
        check("exec_busy", busy, 1);
        check("exec_rsp0v", rsp0_valid, 0);
        check("exec_rsp1v", rsp1_valid, 0);
        check("exec_req0r", req0_ready, 0);
        check("exec_req1r", req1_ready, 0);
        @(posedge clk); #1;
        check_rsp("resp", g, e);
        for (int i = 0; i < stall; i++) begin
            if (g == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            @(posedge clk); #1;
            check_rsp("stall", g, e);
        end
        if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("done");
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        int g;
        bit v0, v1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_func = '0; req0_a = '0; req0_b = '0;
        req1_func = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #3;
        check_idle_outputs("reset");
        check("reset_c", rsp_c, 0);
        check("reset_req0r", req0_ready, 0);
        check("reset_req1r", req1_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed adds on each port
        issue(1, 0, 3'b000, 4'h7, 4'h1, 3'b000, 4'h0, 4'h0, 0, g);
        check("add0_grant", g, 0);
        issue(0, 1, 3'b000, 4'h0, 4'h0, 3'b001, 4'hF, 4'h1, 0, g);
        check("add1_grant", g, 1);

        // Continuous valids on both ports alternate grants
        for (int i = 0; i < 6; i++) begin
            issue(1, 1, 3'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 4'($urandom), 4'($urandom), 0, g);
            check("fair_grant", g, i % 2);
        end

        // Back-pressure with the other port requesting
        issue(1, 1, 3'b110, 4'h3, 4'h5, 3'b000, 4'h2, 4'h2, 5, g);
        check("stall_grant", g, 0);

        issue(0, 1, 3'b000, 4'h0, 4'h0, 3'b010, 4'h5, 4'h0, 0, g);
        issue(0, 1, 3'b000, 4'h0, 4'h0, 3'b111, 4'h9, 4'h9, 0, g);

        // Reset during EXEC of a port 0 add
        req0_valid = 1'b1; req0_func = 3'b000; req0_a = 4'h3; req0_b = 4'h4;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_exec_busy", busy, 1);
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        check("rst_async_c", rsp_c, 0);
        check("rst_async_req0r", req0_ready, 0);
        check("rst_async_req1r", req1_ready, 0);
        @(posedge clk); #1;
        check_idle_outputs("rst_hold");
        check("rst_hold_c", rsp_c, 0);
        rst_n = 1'b1;
        m_ptr = 0;
        issue(1, 1, 3'b011, 4'hC, 4'hA, 3'b100, 4'h1, 4'h2, 0, g);
        check("rst_ptr_grant", g, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(2, 0))
                0:       begin v0 = 1; v1 = 0; end
                1:       begin v0 = 0; v1 = 1; end
                default: begin v0 = 1; v1 = 1; end
            endcase
            issue(v0, v1, 3'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(3, 0)), g);
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Two-port round-robin scheduler that shares one 4-bit ALU datapath (the team's alu_top function set) between two independent requesters. Each requester issues an operation over a valid/ready request channel and receives the result and flags over a valid/ready response channel. The block registers operands, runs one ALU evaluation, and holds the tagged result until the owning requester accepts it. It sits between the two issuing units and the single ALU instance, which it instantiates internally.

## Interface
- No parameters; all widths fixed: func 3, operand/result 4.
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req0_valid / i_req1_valid  input  1  request pending on port 0 / 1
- o_req0_ready / o_req1_ready  output  1  port 0 / 1 request accepted this cycle when valid also high
- i_req0_func / i_req1_func  input  3  ALU function code, 000-111
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  input  4  operands
- o_rsp0_valid / o_rsp1_valid  output  1  result held for port 0 / 1
- i_rsp0_ready / i_rsp1_ready  input  1  port 0 / 1 accepts its result
- o_rsp_c  output  4  result, shared by both response ports
- o_rsp_carry, o_rsp_overflow, o_rsp_zero  output  1 each  flags, shared
- o_busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE: grant chosen combinationally from the valids and the priority pointer ptr (1 bit, reset 0).
  - Both valid: grant port ptr. Only one valid: grant that port. None valid: no grant.
  - o_reqN_ready = (state==IDLE) & grant==N; never high for both ports at once; o_reqN_ready may depend combinationally on i_reqN_valid.
  - On the handshake edge: latch func, a, b and owner id; set ptr = ~granted id; go to EXEC.
- EXEC: ALU evaluates latched operands; at the edge, c and flags are registered into the response registers; go to RESP.
- RESP: o_rspN_valid = 1 only for the owner port. On the edge with i_rspN_ready=1 for the owner, go to IDLE. The ready of the non-owner port is ignored.
- ALU function rules (4-bit, unsigned wrap):
  - 000 and 001 both mean {carry,c} = a+b; overflow = (a[3]==b[3]) & (c[3]!=a[3]); zero = (c==0).
  - 010 ~a; 011 a&b; 100 a|b; 101 a^b; 110 c = (a<b unsigned) ? 1 : 0; 111 c = (a==b) ? 1 : 0.
  - For 010-111, carry, overflow and zero are all 0.
- Request inputs are ignored outside IDLE. Requesters must hold valid and operands stable until ready.

## Timing
- Reset values (asynchronous, immediate on i_rst_n low): state IDLE, ptr 0, o_rsp_c 0, all flags 0, both o_rspN_valid 0, o_busy 0, both o_reqN_ready 0 while i_rst_n is low.
- Latency: accept at edge T. EXEC holds during cycle T..T+1. Response valid is high from after edge T+1.
- Best-case throughput: with rsp ready tied high, a request is accepted at T, the response completes at T+2, and the next accept is at T+3. One operation per 3 cycles.
- Response back-pressure: o_rsp_c, the flags and o_rspN_valid hold unchanged for any number of cycles until accepted.
- Reset mid-EXEC or mid-RESP: the operation is discarded without a response, and all outputs return to reset values.
- Fairness: under continuous valids on both ports, grants strictly alternate 0,1,0,1.

## Test plan
- Port 0: func 000, a=7, b=1 -> c=8, carry 0, overflow 1, zero 0. o_rsp0_valid rises 2 edges after accept; o_rsp1_valid stays 0.
- Port 1: func 001, a=F, b=1 -> c=0, carry 1, overflow 0, zero 1.
- Both ports valid from reset, continuously, with rsp ready high -> grant order 0,1,0,1. Exactly one ready per IDLE cycle; accepts occur every 3 cycles.
- Port 0: func 110, a=3, b=5, with i_rsp0_ready low for 5 cycles -> c=1, flags 0. Output is stable through the stall, and o_busy is high throughout. i_req1_valid=1 during the stall -> o_req1_ready stays 0.
- Port 1: func 010, a=5 -> c=A, flags 0. Func 111, a=9, b=9 -> c=1.
- Assert i_rst_n low during EXEC of a port 0 add -> all outputs 0 immediately. After release, the next both-valid request grants port 0 (ptr=0) and the old response never appears.
